logic_unit_pipe: RTL and testbench

Parametrised, two-stage pipelined logic unit for the ALU datapath: generalises the single-function 4-bit inverter to WIDTH-bit operands and eight selectable bitwise operations. Results and flags are registered and delivered over a valid/ready handshake. It sits between the ALU operand mux and the result/flag writeback stage, alongside the arithmetic units.

---
 rtl/logic_unit_pipe_if.sv | 28 ++
 rtl/logic_unit_pipe.sv | 121 ++++++++++++
 tb/tb_logic_unit_pipe.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/logic_unit_pipe_if.sv
// logic_unit_pipe_if: operand/result handshake bundle for the pipelined logic unit.
// master = producer/consumer side (operand mux + writeback), slave = the unit itself.
interface logic_unit_pipe_if #(
  parameter int unsigned WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             z;
  logic             n;
  logic             cf;
  logic             p;

  modport master (
    output in_valid, op, in1, in2, out_ready,
    input  in_ready, out_valid, out, z, n, cf, p
  );

  modport slave (
    input  in_valid, op, in1, in2, out_ready,
    output in_ready, out_valid, out, z, n, cf, p
  );
endinterface

// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: two-stage pipelined WIDTH-bit logic unit with valid/ready handshake.
// S1 captures operands, S2 holds result and flags. Optional parity flag is enabled by
// defining LOGIC_UNIT_PARITY_EN; otherwise P is tied low and no parity logic exists.
module logic_unit_pipe #(
  parameter int unsigned WIDTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  logic_unit_pipe_if.slave  bus
);

  localparam int unsigned OP_W = 3;

  localparam logic [OP_W-1:0] OP_NOT  = 3'b000;
  localparam logic [OP_W-1:0] OP_AND  = 3'b001;
  localparam logic [OP_W-1:0] OP_OR   = 3'b010;
  localparam logic [OP_W-1:0] OP_XOR  = 3'b011;
  localparam logic [OP_W-1:0] OP_NAND = 3'b100;
  localparam logic [OP_W-1:0] OP_NOR  = 3'b101;
  localparam logic [OP_W-1:0] OP_XNOR = 3'b110;

  logic             s1_valid_q;
  logic [OP_W-1:0]  s1_op_q;
  logic [WIDTH-1:0] s1_a_q;
  logic [WIDTH-1:0] s1_b_q;

  logic             s2_valid_q;
  logic [WIDTH-1:0] s2_res_q;
  logic             s2_z_q;
  logic             s2_n_q;

  logic [WIDTH-1:0] res_d;
  logic             z_d;
  logic             n_d;
  logic             s2_load_c;
  logic             s1_load_c;
  logic             in_fire_c;

  // S2 takes S1 when S1 holds a beat and S2 is empty or draining; S1 reloads when empty or advancing
  assign s2_load_c = s1_valid_q && (!s2_valid_q || bus.out_ready);
  assign s1_load_c = !s1_valid_q || s2_load_c;
  assign in_fire_c = bus.in_valid && s1_load_c;

  // Bitwise operation on the S1 operands and the flags derived from it
  always_comb begin
    res_d = s1_a_q;
    unique case (s1_op_q)
      OP_NOT:  res_d = ~s1_a_q;
      OP_AND:  res_d = s1_a_q & s1_b_q;
      OP_OR:   res_d = s1_a_q | s1_b_q;
      OP_XOR:  res_d = s1_a_q ^ s1_b_q;
      OP_NAND: res_d = ~(s1_a_q & s1_b_q);
      OP_NOR:  res_d = ~(s1_a_q | s1_b_q);
      OP_XNOR: res_d = ~(s1_a_q ^ s1_b_q);
      default: res_d = s1_a_q;
    endcase
    z_d = (res_d == '0);
    n_d = res_d[WIDTH-1];
  end

  // Stage 1: operand capture; valid clears when the beat moves on with nothing behind it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
    end else begin
      if (s1_load_c) begin
        s1_valid_q <= bus.in_valid;
      end
      if (in_fire_c) begin
        s1_op_q <= bus.op;
        s1_a_q  <= bus.in1;
        s1_b_q  <= bus.in2;
      end
    end
  end

  // Stage 2: result and flag registers, held stable while the output is stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_res_q   <= '0;
      s2_z_q     <= 1'b1;
      s2_n_q     <= 1'b0;
    end else if (s2_load_c) begin
      s2_valid_q <= 1'b1;
      s2_res_q   <= res_d;
      s2_z_q     <= z_d;
      s2_n_q     <= n_d;
    end else if (bus.out_ready) begin
      s2_valid_q <= 1'b0;
    end
  end

`ifdef LOGIC_UNIT_PARITY_EN
  logic s2_p_q;

  // Parity flag: 1 when the result holds an odd number of ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_p_q <= 1'b0;
    end else if (s2_load_c) begin
      s2_p_q <= ^res_d;
    end
  end

  assign bus.p = s2_p_q;
`else
  assign bus.p = 1'b0;
`endif

  assign bus.in_ready  = s1_load_c;
  assign bus.out_valid = s2_valid_q;
  assign bus.out       = s2_res_q;
  assign bus.z         = s2_z_q;
  assign bus.n         = s2_n_q;
  assign bus.cf        = 1'b0;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb_logic_unit_pipe: scoreboard bench for logic_unit_pipe (WIDTH = 4).
module tb_logic_unit_pipe;

  localparam int unsigned W = 4;

  typedef struct {
    logic [W-1:0] res;
    int           cyc;
  } sb_entry_t;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;
  int   cyc;
  bit   lat_chk;
  sb_entry_t sb[$];

  logic_unit_pipe_if #(.WIDTH(W)) bus ();

  logic_unit_pipe #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    case (op)
      3'd0:    return ~a;
      3'd1:    return a & b;
      3'd2:    return a | b;
      3'd3:    return a ^ b;
      3'd4:    return ~(a & b);
      3'd5:    return ~(a | b);
      3'd6:    return ~(a ^ b);
      default: return a;
    endcase
  endfunction

  function automatic logic exp_par(input logic [W-1:0] r);
`ifdef LOGIC_UNIT_PARITY_EN
    return ^r;
`else
    return 1'b0;
`endif
  endfunction

  // Drive one beat; returns after the accepting edge (+1)
  task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    sb_entry_t e;
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.in1      = a;
    bus.in2      = b;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        e.res = model(op, a, b);
        e.cyc = cyc;
        sb.push_back(e);
        @(posedge clk);
        #1;
        return;
      end
      @(posedge clk);
      #1;
    end
    check("send_timeout", 32'(bus.in_ready), 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  // Output monitor: pop expected beat on every completed output handshake
  always @(negedge clk) begin
    sb_entry_t e;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_out", 32'(bus.out), 32'hDEAD);
      end else begin
        e = sb.pop_front();
        check("out", 32'(bus.out), 32'(e.res));
        check("z",   32'(bus.z),   32'(e.res == '0));
        check("n",   32'(bus.n),   32'(e.res[W-1]));
        check("cf",  32'(bus.cf),  32'd0);
        check("p",   32'(bus.p),   32'(exp_par(e.res)));
        if (lat_chk) check("latency", 32'(cyc - e.cyc), 32'd2);
      end
    end
  end

  initial begin
    logic [W-1:0] h_out;
    logic         h_z;
    logic         h_n;
    logic         h_p;
    logic [3:0]   ops_a;
    logic [3:0]   ops_b;
    n_chk = 0;
    n_fail = 0;
    cyc = 0;
    lat_chk = 1'b0;
    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.op        = '0;
    bus.in1       = '0;
    bus.in2       = '0;
    bus.out_ready = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out", 32'(bus.out), 32'd0);
    check("rst_z", 32'(bus.z), 32'd1);
    check("rst_n_flag", 32'(bus.n), 32'd0);
    check("rst_p", 32'(bus.p), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // NOT corner cases
    bus.out_ready = 1'b1;
    send(3'd0, 4'b1111, 4'b0000);
    send(3'd0, 4'b0101, 4'b1111);
    bus.in_valid = 1'b0;
    drain();

    // All eight ops on fixed operands
    ops_a = 4'b1100;
    ops_b = 4'b1010;
    for (int k = 0; k < 8; k++) send(3'(k), ops_a, ops_b);
    bus.in_valid = 1'b0;
    drain();

    // Back-to-back 16 beats, fixed latency and order
    lat_chk = 1'b1;
    for (int k = 0; k < 16; k++) send(3'($urandom_range(0, 7)), W'($urandom), W'($urandom));
    bus.in_valid = 1'b0;
    drain();
    lat_chk = 1'b0;

    // Stall: two beats buffered, third refused, outputs frozen
    bus.out_ready = 1'b0;
    send(3'd1, 4'b0110, 4'b0011);
    send(3'd3, 4'b1001, 4'b1111);
    bus.in_valid = 1'b1;
    bus.op  = 3'd2;
    bus.in1 = 4'b0001;
    bus.in2 = 4'b1000;
    @(negedge clk);
    check("stall_in_ready", 32'(bus.in_ready), 32'd0);
    check("stall_out_valid", 32'(bus.out_valid), 32'd1);
    h_out = bus.out;
    h_z = bus.z;
    h_n = bus.n;
    h_p = bus.p;
    check("stall_first_out", 32'(h_out), 32'(model(3'd1, 4'b0110, 4'b0011)));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("hold_out", 32'(bus.out), 32'(h_out));
      check("hold_flags", {29'd0, bus.z, bus.n, bus.p}, {29'd0, h_z, h_n, h_p});
      check("hold_valid", 32'(bus.out_valid), 32'd1);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    send(3'd2, 4'b0001, 4'b1000);
    bus.in_valid = 1'b0;
    drain();

    // Reset mid-stall with both stages full
    bus.out_ready = 1'b0;
    send(3'd0, 4'b0000, 4'b0000);
    send(3'd7, 4'b1010, 4'b0000);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("full_in_ready", 32'(bus.in_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_out", 32'(bus.out), 32'd0);
    check("mid_rst_z", 32'(bus.z), 32'd1);
    check("mid_rst_n", 32'(bus.n), 32'd0);
    check("mid_rst_cf", 32'(bus.cf), 32'd0);
    check("mid_rst_p", 32'(bus.p), 32'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    check("post_rst_out_valid", 32'(bus.out_valid), 32'd0);

    // PASS after reset
    bus.out_ready = 1'b1;
    send(3'd7, 4'b0001, 4'b1110);
    bus.in_valid = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
